// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared definitions for the write-side and read-side controllers of the
//   dual-clock FIFO.
//   - ADDR_WIDTH_DEF / PTR_W : default RAM address width and matching pointer
//     width (one extra bit distinguishes full from empty).
//   - ptr_max_t              : widest pointer the helpers accept. Narrower
//     pointers are zero-extended on the way in and truncated on the way out.
//     Leading zeros do not change a Gray<->binary conversion.
//   - bin2gray / gray2bin    : reflected binary Gray code conversions.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int PTR_W          = ADDR_WIDTH_DEF + 1;
  localparam int MAX_PTR_W      = 16;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ff_sync.sv
// -----------------------------------------------------------------------------
// ff_sync
//   Two-flop synchronizer for a Gray-coded bus that comes from another clock
//   domain. Only one bit of the bus changes at a time, so capturing the bits
//   independently still yields either the old value or the new value.
// Ports
//   clk   in   1           destination clock
//   rstn  in   1           asynchronous, active-low reset
//   d     in   DATA_WIDTH  asynchronous input bus
//   q     out  DATA_WIDTH  input delayed by two clk cycles
// -----------------------------------------------------------------------------
module ff_sync #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] meta;
  logic [DATA_WIDTH-1:0] sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
//   Write-side pointer and flag controller of the dual-clock FIFO. Everything
//   in this block runs on the write clock.
//   - Holds the binary and Gray write pointers and drives the RAM write port.
//   - Brings the read-domain Gray pointer in through a 2-flop synchronizer.
//   - Produces the full, overflow and occupancy status.
// Configuration macro
//   WR_ALMOST_FULL_EN : when defined, adds the o_almost_full output. It is
//                       registered from (next count >= AFULL_THRESH).
// Ports
//   clk              in   1             write-domain clock
//   rstn             in   1             asynchronous, active-low reset
//   i_wr_en          in   1             client write request
//   i_rd_gptr_async  in   ADDR_WIDTH+1  read-domain Gray pointer
//   o_mem_we         out  1             RAM write strobe (combinational)
//   o_wr_addr        out  ADDR_WIDTH    RAM write address
//   o_wr_gptr        out  ADDR_WIDTH+1  Gray write pointer, straight from a flop
//   o_full           out  1             registered full flag
//   o_overflow       out  1             one-cycle pulse after a write while full
//   o_wr_count       out  ADDR_WIDTH+1  registered occupancy (never underestimates)
//   o_almost_full    out  1             only with WR_ALMOST_FULL_EN
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_rd_gptr_async,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_wr_gptr,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_wr_count
`ifdef WR_ALMOST_FULL_EN
  ,
  output logic                  o_almost_full
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rq2_bin;
  logic [PW-1:0] full_match;
  logic [PW-1:0] count_n;
  logic          full_flag;
  logic          full_n;
  logic          ovf_pulse;
  logic [PW-1:0] count;
  logic          push;

  // The full pointer width (address bits plus the wrap bit) is synchronized.
  // Without the wrap bit, full could not be told apart from empty.
  ff_sync #(
    .DATA_WIDTH(PW)
  ) u_rptr_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (i_rd_gptr_async),
    .q   (rq2)
  );

  assign push = i_wr_en & ~full_flag;

  always_comb begin
    wbin_n  = wbin;
    wgray_n = wgray;
    if (push) begin
      wbin_n  = wbin + PW'(1);
      wgray_n = PW'(bin2gray(ptr_max_t'(wbin_n)));
    end
  end

  // The FIFO is full when the write pointer is one lap ahead of the read
  // pointer. In Gray code, that means the top two bits are inverted and the
  // remaining bits are equal.
  always_comb begin
    rq2_bin    = PW'(gray2bin(ptr_max_t'(rq2)));
    full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    full_n     = (wgray_n == full_match);
    count_n    = wbin_n - rq2_bin;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin      <= '0;
      wgray     <= '0;
      full_flag <= 1'b0;
      ovf_pulse <= 1'b0;
      count     <= '0;
    end else begin
      wbin      <= wbin_n;
      wgray     <= wgray_n;
      full_flag <= full_n;
      ovf_pulse <= i_wr_en & full_flag;
      count     <= count_n;
    end
  end

`ifdef WR_ALMOST_FULL_EN
  logic afull_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      afull_flag <= 1'b0;
    end else begin
      afull_flag <= (count_n >= PW'(AFULL_THRESH));
    end
  end

  assign o_almost_full = afull_flag;
`endif

  assign o_mem_we   = push;
  assign o_wr_addr  = wbin[ADDR_WIDTH-1:0];
  assign o_wr_gptr  = wgray;
  assign o_full     = full_flag;
  assign o_overflow = ovf_pulse;
  assign o_wr_count = count;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
module tb_async_fifo_wr_ctrl;

  logic       clk;
  logic       rstn;
  logic       i_wr_en;
  logic [3:0] i_rd_gptr_async;
  logic       o_mem_we;
  logic [2:0] o_wr_addr;
  logic [3:0] o_wr_gptr;
  logic       o_full;
  logic       o_overflow;
  logic [3:0] o_wr_count;
`ifdef WR_ALMOST_FULL_EN
  logic       o_almost_full;
`endif

  int checks = 0;
  int errors = 0;

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (3),
    .AFULL_THRESH(6)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_wr_en        (i_wr_en),
    .i_rd_gptr_async(i_rd_gptr_async),
    .o_mem_we       (o_mem_we),
    .o_wr_addr      (o_wr_addr),
    .o_wr_gptr      (o_wr_gptr),
    .o_full         (o_full),
    .o_overflow     (o_overflow),
    .o_wr_count     (o_wr_count)
`ifdef WR_ALMOST_FULL_EN
    ,
    .o_almost_full  (o_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [3:0] rd;
    logic       we;
    logic [2:0] addr;
    logic [3:0] gptr;
    logic       full;
    logic       ovf;
    logic [3:0] cnt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl[NVEC];

  function automatic vec_t mk(logic wr, logic [3:0] rd, logic we, logic [2:0] addr,
                              logic [3:0] gptr, logic full, logic ovf, logic [3:0] cnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.we = we; v.addr = addr;
    v.gptr = gptr; v.full = full; v.ovf = ovf; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [3:0] to_gray(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_wr_en = 1'b0;
    i_rd_gptr_async = 4'b0000;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    bit full_seen;

    //            wr    rd       we    addr  gptr     full  ovf   cnt
    // fill: 8 pushes with the read pointer at 0
    tbl[0]  = mk(1'b1, 4'b0000, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0, 4'd1);
    tbl[1]  = mk(1'b1, 4'b0000, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0, 4'd2);
    tbl[2]  = mk(1'b1, 4'b0000, 1'b1, 3'd2, 4'b0010, 1'b0, 1'b0, 4'd3);
    tbl[3]  = mk(1'b1, 4'b0000, 1'b1, 3'd3, 4'b0110, 1'b0, 1'b0, 4'd4);
    tbl[4]  = mk(1'b1, 4'b0000, 1'b1, 3'd4, 4'b0111, 1'b0, 1'b0, 4'd5);
    tbl[5]  = mk(1'b1, 4'b0000, 1'b1, 3'd5, 4'b0101, 1'b0, 1'b0, 4'd6);
    tbl[6]  = mk(1'b1, 4'b0000, 1'b1, 3'd6, 4'b0100, 1'b0, 1'b0, 4'd7);
    tbl[7]  = mk(1'b1, 4'b0000, 1'b1, 3'd7, 4'b1100, 1'b1, 1'b0, 4'd8);
    // overflow attempt, then idle
    tbl[8]  = mk(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8);
    tbl[9]  = mk(1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b0, 4'd8);
    // release: read pointer -> 1, full drops on the third edge
    tbl[10] = mk(1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b0, 4'd8);
    tbl[11] = mk(1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b0, 4'd8);
    tbl[12] = mk(1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd7);
    // refill to full
    tbl[13] = mk(1'b1, 4'b0001, 1'b1, 3'd0, 4'b1101, 1'b1, 1'b0, 4'd8);
    // write held while full, release arrives: write on the release edge dropped
    tbl[14] = mk(1'b1, 4'b0011, 1'b0, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8);
    tbl[15] = mk(1'b1, 4'b0011, 1'b0, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8);
    tbl[16] = mk(1'b1, 4'b0011, 1'b0, 3'd1, 4'b1101, 1'b0, 1'b1, 4'd7);
    tbl[17] = mk(1'b1, 4'b0011, 1'b1, 3'd1, 4'b1111, 1'b1, 1'b0, 4'd8);
    tbl[18] = mk(1'b0, 4'b0011, 1'b0, 3'd2, 4'b1111, 1'b1, 1'b0, 4'd8);

    rstn = 1'b0;
    i_wr_en = 1'b0;
    i_rd_gptr_async = 4'b0000;
    #2;
    chk("rst_gptr",  32'(o_wr_gptr),  32'(4'b0000));
    chk("rst_full",  32'(o_full),     32'(1'b0));
    chk("rst_ovf",   32'(o_overflow), 32'(1'b0));
    chk("rst_count", 32'(o_wr_count), 32'(4'd0));
    chk("rst_addr",  32'(o_wr_addr),  32'(3'd0));
    step();
    step();
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      i_wr_en = tbl[i].wr;
      i_rd_gptr_async = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_we", i),   32'(o_mem_we),   32'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), 32'(o_wr_addr),  32'(tbl[i].addr));
      step();
      chk($sformatf("v%0d_gptr", i), 32'(o_wr_gptr),  32'(tbl[i].gptr));
      chk($sformatf("v%0d_full", i), 32'(o_full),     32'(tbl[i].full));
      chk($sformatf("v%0d_ovf", i),  32'(o_overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_cnt", i),  32'(o_wr_count), 32'(tbl[i].cnt));
    end

    // Asynchronous reset in the middle of a cycle, state non-zero.
    #2;
    rstn = 1'b0;
    i_wr_en = 1'b0;
    #1;
    chk("midrst_gptr",  32'(o_wr_gptr),  32'(4'b0000));
    chk("midrst_full",  32'(o_full),     32'(1'b0));
    chk("midrst_ovf",   32'(o_overflow), 32'(1'b0));
    chk("midrst_count", 32'(o_wr_count), 32'(4'd0));
    chk("midrst_addr",  32'(o_wr_addr),  32'(3'd0));
    step();
    i_rd_gptr_async = 4'b0000;
    step();
    rstn = 1'b1;

    // Wrap: 16 pushes, read pointer trailing two behind.
    full_seen = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      i_wr_en = 1'b1;
      i_rd_gptr_async = (p >= 3) ? to_gray(4'(p - 3)) : 4'b0000;
      step();
      if (o_full) full_seen = 1'b1;
      if (p == 15) chk("wrap_gptr15", 32'(o_wr_gptr), 32'(4'b1000));
      if (p == 16) begin
        chk("wrap_gptr16", 32'(o_wr_gptr),  32'(4'b0000));
        chk("wrap_addr",   32'(o_wr_addr),  32'(3'd0));
        chk("wrap_count",  32'(o_wr_count), 32'(4'd5));
      end
    end
    i_wr_en = 1'b0;
    chk("wrap_no_full", 32'(full_seen), 32'(1'b0));

`ifdef WR_ALMOST_FULL_EN
    do_reset();
    for (int p = 1; p <= 6; p++) begin
      i_wr_en = 1'b1;
      step();
      if (p == 5) begin
        chk("afull5", 32'(o_almost_full), 32'(1'b0));
        chk("cnt5",   32'(o_wr_count),    32'(4'd5));
      end
      if (p == 6) begin
        chk("afull6", 32'(o_almost_full), 32'(1'b1));
        chk("cnt6",   32'(o_wr_count),    32'(4'd6));
      end
    end
    i_wr_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
